// File: rtl/bcd_bin_seq_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned DIGITS_DEF = 3;
  localparam int unsigned BIN_W_DEF  = 10;

  function automatic logic digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_bin_seq_if.sv
// Valid/ready handshake bundle: BCD in, binary result and error flag out.
interface bcd_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits >= 8 lose 3 (mod 16).
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  always_comb begin
    o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;
  end

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle)
// with valid/ready handshakes on input and output.
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bcd_bin_seq_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;
  logic [BIN_W-1:0]   r_bout;

  state_t             w_state_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_err_nxt;
  logic [BIN_W-1:0]   w_bout_nxt;

  logic [BCD_W-1:0]   w_bcd_shift;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BIN_W-1:0]   w_bin_shift;
  logic               w_in_ok;

  // {bcd, bin} shifted right as one word; the BCD LSB enters the binary MSB.
  assign w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};
  assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d (w_bcd_shift[4*g +: 4]),
      .o_d (w_bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    w_in_ok = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (!digit_valid(bus.bcd_in[4*k +: 4])) begin
        w_in_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_bout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_bin   <= w_bin_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_bout  <= w_bout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_bin_nxt   = r_bin;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_bout_nxt  = r_bout;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_bcd_nxt   = bus.bcd_in;
          w_bin_nxt   = '0;
          w_count_nxt = '0;
          if (w_in_ok) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = SHIFT;
          end else begin
            w_err_nxt   = 1'b1;
            w_bout_nxt  = '0;
            w_state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        w_bcd_nxt   = w_bcd_adj;
        w_bin_nxt   = w_bin_shift;
        w_count_nxt = r_count + 1'b1;
        if (r_count == LAST) begin
          // Result register is loaded from the final shift so it stays put after the handshake.
          w_bout_nxt  = w_bin_shift;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.bin_out   = r_bout;
  assign bus.err       = r_err;

  // After the last shift every BCD bit must have migrated into the binary word.
  a_residue_zero: assert property (
    @(posedge clk) disable iff (rst)
    (r_state == SHIFT && r_count == LAST) |-> (w_bcd_adj == '0)
  );

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Directed bench for bcd_bin_seq: latency, back-to-back, error path,
// backpressure, mid-conversion reset and a 0..999 sweep.
module tb_bcd_bin_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present v, wait for acceptance, then count edges (accepting edge = 1)
  // until out_valid is seen. Returns at the negedge where out_valid is high.
  task automatic do_conv(input logic [11:0] v, input logic rdy,
                         output int lat, output logic [9:0] res, output logic e);
    int n;
    n = 0;
    bus.bcd_in    = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL conv_timeout bcd=%h: out_valid=0, required 1 within 40 cycles", v);
    end
    res = bus.bin_out;
    e   = bus.err;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100 || bus.bin_out !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b err=%b bin_out=%0d, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.err, bus.bin_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max_999();
    int lat; logic [9:0] res; logic e;
    do_conv(12'h999, 1'b1, lat, res, e);
    checks++;
    if (res !== 10'h3E7 || e !== 1'b0) begin
      failures++;
      $display("FAIL max_999: bin_out=%0d err=%b, required 999 0", res, e);
    end
    checks++;
    if (lat !== 11) begin
      failures++;
      $display("FAIL max_999_latency: %0d edges, required 11", lat);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL max_999_pulse: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [3];
    logic [9:0]  exps [3];
    int cyc, k, got, last, bad_rdy;
    logic acc, busy;
    vals = '{12'h000, 12'h509, 12'h100};
    exps = '{10'd0, 10'd509, 10'd100};
    cyc = 0; k = 0; got = 0; last = 0; bad_rdy = 0; busy = 1'b0;
    bus.bcd_in    = vals[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      acc = bus.in_ready && bus.in_valid;
      if (busy && bus.in_ready) bad_rdy++;
      if (bus.out_valid) begin
        checks++;
        if (bus.bin_out !== exps[got] || bus.err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_result%0d: bin_out=%0d err=%b, required %0d 0", got, bus.bin_out, bus.err, exps[got]);
        end
        checks++;
        if (bad_rdy != 0) begin
          failures++;
          $display("FAIL b2b_in_ready%0d: in_ready high %0d times while busy, required 0", got, bad_rdy);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != 12) begin
            failures++;
            $display("FAIL b2b_spacing%0d: %0d cycles, required 12", got, cyc - last);
          end
        end
        last = cyc; got++; bad_rdy = 0; busy = 1'b0;
      end
      @(posedge clk);
      if (acc) begin k++; busy = 1'b1; end
      @(negedge clk);
      cyc++;
      if (k < 3) bus.bcd_in = vals[k];
      else       bus.in_valid = 1'b0;
    end
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count: %0d results, required 3", got);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_err();
    int lat; logic [9:0] res; logic e;
    do_conv(12'h1A3, 1'b1, lat, res, e);
    checks++;
    if (e !== 1'b1 || res !== 10'd0 || lat !== 1) begin
      failures++;
      $display("FAIL err_1A3: err=%b bin_out=%0d latency=%0d, required 1 0 1", e, res, lat);
    end
    do_conv(12'h123, 1'b1, lat, res, e);
    checks++;
    if (e !== 1'b0 || res !== 10'd123 || lat !== 11) begin
      failures++;
      $display("FAIL after_err_123: err=%b bin_out=%0d latency=%0d, required 0 123 11", e, res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat, bad; logic [9:0] res; logic e;
    do_conv(12'h255, 1'b0, lat, res, e);
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.out_valid !== 1'b1 || bus.bin_out !== 10'd255 || bus.in_ready !== 1'b0 || bus.err !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: %0d unstable cycles (last bin_out=%0d), required 0", bad, bus.bin_out);
    end
    // Offer a new input at the release cycle; it must not be taken.
    bus.out_ready = 1'b1;
    bus.bcd_in    = 12'h777;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bin_out !== 10'd255) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b bin_out=%0d, required 0 1 255",
               bus.out_valid, bus.in_ready, bus.bin_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, seen; logic [9:0] res; logic e;
    bus.bcd_in    = 12'h876;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100 || bus.bin_out !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid_shift: in_ready=%b out_valid=%b err=%b bin_out=%0d, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.err, bus.bin_out);
    end
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_partial: out_valid seen %0d times, required 0", seen);
    end
    do_conv(12'h042, 1'b1, lat, res, e);
    checks++;
    if (res !== 10'd42 || e !== 1'b0 || lat !== 11) begin
      failures++;
      $display("FAIL post_reset_042: bin_out=%0d err=%b latency=%0d, required 42 0 11", res, e, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int lat; logic [9:0] res; logic e; logic [11:0] v;
    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_conv(v, 1'b0, lat, res, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (bus.bin_out !== 10'(i) || bus.err !== 1'b0 || res !== 10'(i)) begin
        failures++;
        $display("FAIL sweep bcd=%h: bin_out=%0d err=%b, required %0d 0", v, bus.bin_out, bus.err, i);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_max_999();
    test_back_to_back();
    test_err();
    test_backpressure();
    test_reset_mid_shift();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_bin_seq.md
Name: bcd_bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the team's binary-to-BCD block. It accepts a packed 3-digit BCD value and produces its 10-bit binary equivalent using reverse double-dabble: shift right one bit per cycle, then subtract 3 from each digit that is >= 8. It sits between the keypad/display digit path and the binary arithmetic datapath, with valid/ready handshakes on both sides.

Parameters:
DIGITS, 3, number of BCD digits in the input.
BIN_W, 10, binary output width. Must satisfy 2^BIN_W >= 10^DIGITS. Also equals the number of shift cycles.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  reset; synchronous and active-high.
in_valid  input  1  bcd_in is valid.
in_ready  output  1  block can accept a new value.
bcd_in  input  4*DIGITS  packed BCD; bits [3:0] are the units digit.
out_valid  output  1  bin_out and err are valid.
out_ready  input  1  consumer accepts the result.
bin_out  output  BIN_W  binary result.
err  output  1  the input contained a digit > 9.

Behaviour:
- Architecture: one clock, one clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; bin_out=0; err=0; internal bcd_reg, bin_reg and count all 0.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch bcd_in into bcd_reg, clear bin_reg, set count=0.
  - If any digit is > 9: go to DONE with err=1 and bin_out=0. No shifting takes place.
  - Otherwise go to SHIFT.
- State SHIFT:
  - in_ready=0; in_valid is ignored.
  - Each cycle, shift {bcd_reg, bin_reg} right by 1. The bcd_reg LSB moves into the bin_reg MSB.
  - After the shift, for each digit of the shifted bcd_reg: if the digit >= 8, subtract 3. Digits are adjusted independently, mod 16.
  - count increments each cycle. When count == BIN_W-1, go to DONE.
- State DONE:
  - out_valid=1; bin_out=bin_reg; err held; in_ready=0.
  - bin_out and err stay stable while out_ready=0. There is no timeout.
  - On out_ready: the next cycle returns to IDLE with out_valid=0.
  - bin_out keeps its last value after the handshake; only out_valid qualifies it.
- Latency:
  - Valid input: out_valid rises BIN_W+1 clock edges after the accepting edge.
  - Invalid input: out_valid rises 1 edge after the accepting edge.
- Throughput: no overlap between conversions; at best one conversion every BIN_W+2 cycles.
- Width rules:
  - After BIN_W shifts, bcd_reg must be all zero.
  - A nonzero residue is a design error; flag it with a simulation assertion, not a port.
- Boundary conditions:
  - Input 0: bin_out=0, err=0, full latency still applies.
  - Input 999: bin_out=999 (0x3E7).
  - A digit exactly 9 is valid. Digits A-F set err.
  - in_valid and out_ready both high in DONE: the new input is not taken that cycle, because in_ready=0.
  - rst asserted in any state, including mid-SHIFT: return to reset values on that edge. No partial result appears.
  - in_valid dropped during SHIFT: no effect.

Decomposition:
- Package bcd_pkg holds:
  - typedef state_t {IDLE, SHIFT, DONE};
  - localparams DIGITS_DEF=3 and BIN_W_DEF=10;
  - function digit_valid(4-bit) returning (d <= 9).
- Sub-module bcd_digit_adj: purely combinational, 4-bit in / 4-bit out, implementing "d >= 8 ? d-3 : d". Instantiate it DIGITS times via generate.
- The FSM, counter and registers stay in bcd_bin_seq.

Test Plan:
1. bcd_in=0x999, out_ready=1 -> bin_out=999 (0x3E7), err=0, out_valid exactly 11 edges after acceptance, pulse 1 cycle wide.
2. bcd_in=0x000, then 0x509, then 0x100 back-to-back with in_valid held high -> 0, 509, 100 in order; in_ready=0 during each conversion; 12-cycle spacing between results.
3. bcd_in=0x1A3 -> err=1, bin_out=0, out_valid 1 edge after acceptance; next input 0x123 -> 123, err=0.
4. Backpressure: bcd_in=0x255, out_ready held low 6 cycles -> out_valid=1 and bin_out=255 stable for all 6 cycles; in_ready=0; release -> IDLE next cycle.
5. rst asserted on the 5th SHIFT cycle of 0x876 -> next edge gives reset values; a following 0x042 converts to 42 with full latency.
6. Exhaustive sweep 0..999 via random-gap handshakes on both sides, compared against a reference model -> every result matches, and the final bcd_reg residue assertion never fires.
